// File: rtl/uart_img_loader.sv
// Frames a sync-led, checksummed 28x28 image from the UART byte stream into the image buffer
// and holds the buffer for the inference engine until it releases it.
module uart_img_loader #(
    parameter int          PIXELS      = 784,
    parameter int          ADDR_W      = 10,
    parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
    parameter int          TIMEOUT_CYC = 21700
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rx_done,
    input  logic [7:0]        rx_byte,
    input  logic              infer_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              img_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pix_cnt;
    logic [7:0]        sum;
    logic [TMR_W-1:0]  timer;

    wire timed_out = (timer == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            sum       <= '0;
            timer     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            img_valid <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            img_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_done && rx_byte == SYNC_BYTE) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        pix_cnt <= '0;
                        sum     <= '0;
                        timer   <= '0;
                    end
                end
                LOAD: begin
                    // a byte arriving on the timeout cycle still counts
                    if (rx_done) begin
                        wr_en   <= 1'b1;
                        wr_addr <= pix_cnt;
                        wr_data <= rx_byte;
                        sum     <= sum + rx_byte;
                        timer   <= '0;
                        if (pix_cnt == ADDR_W'(PIXELS - 1))
                            state <= CHECK;
                        else
                            pix_cnt <= pix_cnt + 1'b1;
                    end else if (timed_out) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CHECK: begin
                    if (rx_done) begin
                        timer <= '0;
                        if (rx_byte == sum) begin
                            img_valid <= 1'b1;
                            state     <= READY;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end
                    end else if (timed_out) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                READY: begin
                    if (infer_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_img_loader.sv
// Directed bench for uart_img_loader: cycle vectors for the start of a frame, then
// hand-written full-frame, checksum, timeout, hold and reset sequences.
module tb_uart_img_loader;

    localparam int PIXELS      = 784;
    localparam int ADDR_W      = 10;
    localparam int TIMEOUT_CYC = 21700;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              rx_done = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              infer_done = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              img_valid;
    logic              frame_err;
    logic              busy;

    uart_img_loader dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rx_done    (rx_done),
        .rx_byte    (rx_byte),
        .infer_done (infer_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .img_valid  (img_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_err = 0;

    // write/pulse monitor, sampled on the falling edge
    int wr_cnt = 0, iv_cnt = 0, fe_cnt = 0, pat_err = 0, seq_err = 0;
    int last_addr = -1, last_data = -1, prev_addr = -1;
    bit chk_pat = 1'b0;

    always @(negedge sys_clk) begin
        if (wr_en) begin
            wr_cnt++;
            if (chk_pat && wr_data != wr_addr[7:0]) pat_err++;
            if (chk_pat && int'(wr_addr) != 0 && int'(wr_addr) != prev_addr + 1) seq_err++;
            prev_addr = int'(wr_addr);
            last_addr = int'(wr_addr);
            last_data = int'(wr_data);
        end
        if (img_valid) iv_cnt++;
        if (frame_err) fe_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b1;
        rx_byte = b;
        tick();
        rx_done = 1'b0;
    endtask

    // sync + pixels i mod 256, then checksum; returns right after the checksum edge
    task automatic send_frame(input logic [7:0] ck);
        send_byte(8'hAA);
        for (int i = 0; i < PIXELS; i++) begin
            logic [7:0] p;
            p = 8'(i);
            send_byte(p);
        end
        send_byte(ck);
    endtask

    task automatic pulse_infer();
        infer_done = 1'b1;
        tick();
        infer_done = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic       rx_done;
        logic [7:0] rx_byte;
        logic       infer_done;
        logic       wr_en;
        int         wr_addr;
        int         wr_data;
        logic       busy;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int w0, iv0, fe0, k;
        bit seen;

        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 0,      1'b0};
        vecs[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 0, 0,      1'b0};
        vecs[2]  = '{1'b1, 8'h55, 1'b0, 1'b0, 0, 0,      1'b0};
        vecs[3]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 0, 0,      1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 0,      1'b0};
        vecs[5]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 0, 0,      1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 0,      1'b1};
        vecs[7]  = '{1'b1, 8'h10, 1'b0, 1'b1, 0, 'h10,   1'b1};
        vecs[8]  = '{1'b1, 8'hAA, 1'b0, 1'b1, 1, 'hAA,   1'b1};
        vecs[9]  = '{1'b1, 8'h20, 1'b0, 1'b1, 2, 'h20,   1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 0,      1'b1};
        vecs[11] = '{1'b1, 8'h05, 1'b0, 1'b1, 3, 'h05,   1'b1};

        // reset state
        #1;
        chk("reset wr_en", int'(wr_en), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset img_valid", int'(img_valid), 0);
        chk("reset frame_err", int'(frame_err), 0);
        do_reset();

        // cycle vectors: garbage in IDLE, sync, pixels incl. 0xAA, infer_done ignored
        foreach (vecs[i]) begin
            rx_done    = vecs[i].rx_done;
            rx_byte    = vecs[i].rx_byte;
            infer_done = vecs[i].infer_done;
            tick();
            chk($sformatf("vec%0d wr_en", i), int'(wr_en), int'(vecs[i].wr_en));
            chk($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].busy));
            chk($sformatf("vec%0d pulses", i), int'(img_valid | frame_err), 0);
            if (vecs[i].wr_en) begin
                chk($sformatf("vec%0d wr_addr", i), int'(wr_addr), vecs[i].wr_addr);
                chk($sformatf("vec%0d wr_data", i), int'(wr_data), vecs[i].wr_data);
            end
        end
        rx_done = 1'b0;
        infer_done = 1'b0;
        do_reset();
        chk_pat = 1'b1;

        // nominal frame
        w0 = wr_cnt; iv0 = iv_cnt; fe0 = fe_cnt;
        send_frame(8'hF8);
        chk("nom img_valid latency", int'(img_valid), 1);
        chk("nom busy", int'(busy), 1);
        tick();
        chk("nom img_valid one cycle", int'(img_valid), 0);
        chk("nom writes", wr_cnt - w0, PIXELS);
        chk("nom last addr", last_addr, PIXELS - 1);
        chk("nom last data", last_data, 'h0F);
        chk("nom img_valid count", iv_cnt - iv0, 1);
        chk("nom frame_err count", fe_cnt - fe0, 0);

        // buffer hold: bytes ignored, then release
        w0 = wr_cnt;
        send_byte(8'h01); send_byte(8'hAA); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h03);
        tick();
        chk("hold writes", wr_cnt - w0, 0);
        chk("hold busy", int'(busy), 1);
        pulse_infer();
        chk("release busy", int'(busy), 0);
        pulse_infer();
        chk("idle infer busy", int'(busy), 0);

        // bad checksum, then a good frame
        w0 = wr_cnt; iv0 = iv_cnt; fe0 = fe_cnt;
        send_frame(8'hF9);
        chk("bad frame_err", int'(frame_err), 1);
        chk("bad busy", int'(busy), 0);
        tick();
        chk("bad writes", wr_cnt - w0, PIXELS);
        chk("bad img_valid count", iv_cnt - iv0, 0);
        chk("bad frame_err count", fe_cnt - fe0, 1);
        iv0 = iv_cnt;
        send_frame(8'hF8);
        tick();
        chk("after bad img_valid", iv_cnt - iv0, 1);
        pulse_infer();

        // timeout after 100 pixels
        w0 = wr_cnt; fe0 = fe_cnt;
        send_byte(8'hAA);
        for (int i = 0; i < 100; i++) begin
            logic [7:0] p;
            p = 8'(i);
            send_byte(p);
        end
        seen = 1'b0;
        k = 0;
        for (int c = 1; c <= TIMEOUT_CYC + 20 && !seen; c++) begin
            tick();
            if (frame_err) begin
                seen = 1'b1;
                k = c;
            end
        end
        chk("timeout latency", k, TIMEOUT_CYC);
        chk("timeout busy", int'(busy), 0);
        chk("timeout writes", wr_cnt - w0, 100);
        chk("timeout last addr", last_addr, 99);
        w0 = wr_cnt;
        send_byte(8'hAA);
        send_byte(8'h00);
        chk("post-timeout wr_en", int'(wr_en), 1);
        chk("post-timeout addr", int'(wr_addr), 0);
        do_reset();

        // reset mid-LOAD
        send_byte(8'hAA);
        for (int i = 0; i < 300; i++) begin
            logic [7:0] p;
            p = 8'(i);
            send_byte(p);
        end
        sys_rst_n = 1'b0;
        #1;
        chk("rst wr_en", int'(wr_en), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst wr_addr", int'(wr_addr), 0);
        tick();
        sys_rst_n = 1'b1;
        tick();
        w0 = wr_cnt; iv0 = iv_cnt; fe0 = fe_cnt;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        tick();
        chk("post-rst writes", wr_cnt - w0, 0);
        chk("post-rst busy", int'(busy), 0);
        send_frame(8'hF8);
        tick();
        chk("post-rst frame writes", wr_cnt - w0, PIXELS);
        chk("post-rst img_valid", iv_cnt - iv0, 1);
        chk("post-rst frame_err", fe_cnt - fe0, 0);

        chk("address sequence errors", seq_err, 0);
        chk("pixel data errors", pat_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
